// File: rtl/fnn_load_ctrl_pkg.sv
// Shared constants, state encoding and layer geometry for the FNN load controller.
// Pure declarations: no latency, no backpressure.
package fnn_load_ctrl_pkg;

  localparam int WEIGHT_WIDTH  = 16;
  localparam int PART_NO_WIDTH = 7;
  localparam int NO_OF_INPUTS  = 784;
  localparam int NN1           = 40;
  localparam int NN2           = 10;
  localparam int NN3           = 10;
  localparam int NN4           = 10;
  localparam int INDATA_WIDTH  = 16;

  localparam int W_ADDR_W  = 15;
  localparam int PX_ADDR_W = 10;
  localparam int PIX_CNT_W = 10;
  localparam int FAN_W     = 10;
  localparam int LAYER_W   = 2;
  localparam int WBUS_W    = WEIGHT_WIDTH + PART_NO_WIDTH;

  // Flat stream layout: each layer is its weight block followed by its bias block.
  localparam int L1_W_BASE = 0;
  localparam int L1_B_BASE = L1_W_BASE + NO_OF_INPUTS * NN1;
  localparam int L2_W_BASE = L1_B_BASE + NN1;
  localparam int L2_B_BASE = L2_W_BASE + NN1 * NN2;
  localparam int L3_W_BASE = L2_B_BASE + NN2;
  localparam int L3_B_BASE = L3_W_BASE + NN2 * NN3;
  localparam int L4_W_BASE = L3_B_BASE + NN3;
  localparam int L4_B_BASE = L4_W_BASE + NN3 * NN4;
  localparam int DEPTH     = L4_B_BASE + NN4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_W,
    ST_READY,
    ST_IMG,
    ST_WAIT
  } state_t;

  typedef struct packed {
    logic [LAYER_W-1:0]      layer;
    logic                    bias;
    logic [W_ADDR_W-1:0]     addr;
    logic [WEIGHT_WIDTH-1:0] data;
  } w_wr_t;

  typedef struct packed {
    logic [PX_ADDR_W-1:0]    addr;
    logic [INDATA_WIDTH-1:0] data;
  } px_wr_t;

  function automatic logic [FAN_W-1:0] fan_in_of(input logic [LAYER_W-1:0] layer);
    case (layer)
      2'd0:    return FAN_W'(NO_OF_INPUTS);
      2'd1:    return FAN_W'(NN1);
      2'd2:    return FAN_W'(NN2);
      default: return FAN_W'(NN3);
    endcase
  endfunction

  function automatic logic [PART_NO_WIDTH-1:0] nn_of(input logic [LAYER_W-1:0] layer);
    case (layer)
      2'd0:    return PART_NO_WIDTH'(NN1);
      2'd1:    return PART_NO_WIDTH'(NN2);
      2'd2:    return PART_NO_WIDTH'(NN3);
      default: return PART_NO_WIDTH'(NN4);
    endcase
  endfunction

endpackage

// File: rtl/fnn_load_ctrl_if.sv
// Load/stream bundle between control_FNN (master) and the load controller (slave).
// Wiring only: no latency; flow control is the weight_valid and ready_in/FNN_ready_to_accept pairs.
interface fnn_load_ctrl_if;
  import fnn_load_ctrl_pkg::*;

  logic                      load_weights;
  logic                      weight_valid;
  logic [WBUS_W-1:0]         weight_bus;
  logic                      start_FNN;
  logic                      ready_in;
  logic [INDATA_WIDTH-1:0]   input_image;
  logic                      compute_done;

  logic                      FNN_ready;
  logic                      FNN_ready_to_accept;
  logic                      w_wr_en;
  logic [LAYER_W-1:0]        w_wr_layer;
  logic                      w_wr_bias;
  logic [W_ADDR_W-1:0]       w_wr_addr;
  logic [WEIGHT_WIDTH-1:0]   w_wr_data;
  logic                      px_wr_en;
  logic [PX_ADDR_W-1:0]      px_wr_addr;
  logic [INDATA_WIDTH-1:0]   px_wr_data;
  logic                      compute_start;
  logic                      err_part;

  modport master (
    output load_weights, weight_valid, weight_bus, start_FNN, ready_in, input_image, compute_done,
    input  FNN_ready, FNN_ready_to_accept, w_wr_en, w_wr_layer, w_wr_bias, w_wr_addr, w_wr_data,
           px_wr_en, px_wr_addr, px_wr_data, compute_start, err_part
  );

  modport slave (
    input  load_weights, weight_valid, weight_bus, start_FNN, ready_in, input_image, compute_done,
    output FNN_ready, FNN_ready_to_accept, w_wr_en, w_wr_layer, w_wr_bias, w_wr_addr, w_wr_data,
           px_wr_en, px_wr_addr, px_wr_data, compute_start, err_part
  );

endinterface

// File: rtl/fnn_load_ctrl_seg_tracker.sv
// Tracks layer/bias/offset of the next stream word plus its expected neuron index; state advances one edge after step.
// No backpressure: advances only on step, holds otherwise.
module fnn_load_ctrl_seg_tracker
  import fnn_load_ctrl_pkg::*;
(
  input  logic                     clk,
  input  logic                     restart,
  input  logic                     step,
  output logic [LAYER_W-1:0]       layer,
  output logic                     bias,
  output logic [W_ADDR_W-1:0]      offset,
  output logic [PART_NO_WIDTH-1:0] exp_part,
  output logic                     last
);

  logic [FAN_W-1:0]         in_idx;
  logic [PART_NO_WIDTH-1:0] neuron;
  logic [FAN_W-1:0]         fan;
  logic [PART_NO_WIDTH-1:0] nn;

  assign fan      = fan_in_of(layer);
  assign nn       = nn_of(layer);
  assign exp_part = bias ? offset[PART_NO_WIDTH-1:0] : neuron;
  assign last     = (layer == LAYER_W'(3)) && bias && (offset == W_ADDR_W'(NN4 - 1));

  // Nested input/neuron counters replace addr/fan_in division for the expected tag.
  always_ff @(posedge clk) begin
    if (!restart) begin
      layer  <= '0;
      bias   <= 1'b0;
      offset <= '0;
      in_idx <= '0;
      neuron <= '0;
    end else if (step) begin
      if (!bias) begin
        if (in_idx == fan - FAN_W'(1)) begin
          in_idx <= '0;
          if (neuron == nn - PART_NO_WIDTH'(1)) begin
            neuron <= '0;
            bias   <= 1'b1;
            offset <= '0;
          end else begin
            neuron <= neuron + PART_NO_WIDTH'(1);
            offset <= offset + W_ADDR_W'(1);
          end
        end else begin
          in_idx <= in_idx + FAN_W'(1);
          offset <= offset + W_ADDR_W'(1);
        end
      end else begin
        if (offset == W_ADDR_W'(nn) - W_ADDR_W'(1)) begin
          bias   <= 1'b0;
          offset <= '0;
          layer  <= layer + LAYER_W'(1);
        end else begin
          offset <= offset + W_ADDR_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/fnn_load_ctrl.sv
// Decodes the weight stream into memory writes, then takes one image per inference; writes appear one cycle after accept.
// Backpressure: FNN_ready_to_accept gates pixels; weights are taken whenever load_weights & weight_valid in LOAD_W.
module fnn_load_ctrl
  import fnn_load_ctrl_pkg::*;
(
  input  logic           clk,
  input  logic           restart,
  fnn_load_ctrl_if.slave bus
);

  state_t                   state, state_nxt;
  logic                     w_acc, px_acc, rta, last_px;
  logic [LAYER_W-1:0]       seg_layer;
  logic                     seg_bias, seg_last;
  logic [W_ADDR_W-1:0]      seg_offset;
  logic [PART_NO_WIDTH-1:0] exp_part;
  logic [PIX_CNT_W-1:0]     pix_cnt;

  w_wr_t  w_wr_q;
  px_wr_t px_wr_q;
  logic   w_wr_en_q, px_wr_en_q, compute_start_q, fnn_ready_q, err_part_q;

  assign w_acc   = (state == ST_LOAD_W) && bus.load_weights && bus.weight_valid;
  assign rta     = (state == ST_IMG) && (pix_cnt < PIX_CNT_W'(NO_OF_INPUTS));
  assign px_acc  = bus.ready_in && rta;
  assign last_px = px_acc && (pix_cnt == PIX_CNT_W'(NO_OF_INPUTS - 1));

  fnn_load_ctrl_seg_tracker u_seg (
    .clk      (clk),
    .restart  (restart),
    .step     (w_acc),
    .layer    (seg_layer),
    .bias     (seg_bias),
    .offset   (seg_offset),
    .exp_part (exp_part),
    .last     (seg_last)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (bus.load_weights)    state_nxt = ST_LOAD_W;
      ST_LOAD_W: if (w_acc && seg_last)   state_nxt = ST_READY;
      ST_READY:  if (bus.start_FNN)       state_nxt = ST_IMG;
      ST_IMG:    if (last_px)             state_nxt = ST_WAIT;
      ST_WAIT:   if (bus.compute_done)    state_nxt = ST_READY;
      default:                            state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!restart) begin
      state           <= ST_IDLE;
      pix_cnt         <= '0;
      w_wr_q          <= '0;
      px_wr_q         <= '0;
      w_wr_en_q       <= 1'b0;
      px_wr_en_q      <= 1'b0;
      compute_start_q <= 1'b0;
      fnn_ready_q     <= 1'b0;
      err_part_q      <= 1'b0;
    end else begin
      state           <= state_nxt;
      w_wr_en_q       <= w_acc;
      px_wr_en_q      <= px_acc;
      compute_start_q <= last_px;
      if (w_acc) begin
        w_wr_q <= '{layer: seg_layer, bias: seg_bias, addr: seg_offset,
                    data: bus.weight_bus[WEIGHT_WIDTH-1:0]};
        // A mistagged word is still written; the flag only reports it.
        if (bus.weight_bus[WEIGHT_WIDTH +: PART_NO_WIDTH] != exp_part) err_part_q <= 1'b1;
        if (seg_last) fnn_ready_q <= 1'b1;
      end
      if (state == ST_READY && bus.start_FNN) begin
        pix_cnt <= '0;
      end else if (px_acc) begin
        pix_cnt <= pix_cnt + PIX_CNT_W'(1);
      end
      if (px_acc) px_wr_q <= '{addr: pix_cnt, data: bus.input_image};
    end
  end

  assign bus.FNN_ready           = fnn_ready_q;
  assign bus.FNN_ready_to_accept = rta;
  assign bus.w_wr_en             = w_wr_en_q;
  assign bus.w_wr_layer          = w_wr_q.layer;
  assign bus.w_wr_bias           = w_wr_q.bias;
  assign bus.w_wr_addr           = w_wr_q.addr;
  assign bus.w_wr_data           = w_wr_q.data;
  assign bus.px_wr_en            = px_wr_en_q;
  assign bus.px_wr_addr          = px_wr_q.addr;
  assign bus.px_wr_data          = px_wr_q.data;
  assign bus.compute_start       = compute_start_q;
  assign bus.err_part            = err_part_q;

endmodule

// File: tb/tb_fnn_load_ctrl.sv
// Random-stimulus bench for fnn_load_ctrl against a division-based stream decoder and queue scoreboards.
// Drives inputs and samples outputs on the falling edge.
module tb_fnn_load_ctrl;
  import fnn_load_ctrl_pkg::*;

  logic clk = 1'b0;
  logic restart;
  int   total = 0;
  int   bad   = 0;

  fnn_load_ctrl_if bus ();

  fnn_load_ctrl dut (
    .clk     (clk),
    .restart (restart),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  logic [66:0] outs;
  assign outs = {bus.FNN_ready, bus.FNN_ready_to_accept, bus.w_wr_en, bus.w_wr_layer, bus.w_wr_bias,
                 bus.w_wr_addr, bus.w_wr_data, bus.px_wr_en, bus.px_wr_addr, bus.px_wr_data,
                 bus.compute_start, bus.err_part};

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference decoder: walks the layer table with plain arithmetic.
  task automatic decode(input int idx, output int layer, output int bias, output int addr, output int part);
    int fan [4] = '{NO_OF_INPUTS, NN1, NN2, NN3};
    int nn  [4] = '{NN1, NN2, NN3, NN4};
    int rem = idx;
    layer = 0; bias = 0; addr = 0; part = 0;
    for (int l = 0; l < 4; l++) begin
      if (rem < fan[l] * nn[l]) begin
        layer = l; bias = 0; addr = rem; part = rem / fan[l];
        return;
      end
      rem -= fan[l] * nn[l];
      if (rem < nn[l]) begin
        layer = l; bias = 1; addr = rem; part = rem;
        return;
      end
      rem -= nn[l];
    end
  endtask

  logic [33:0] wq [$];
  int          wi [$];
  logic [25:0] pq [$];
  int          n_wr = 0;
  int          n_px = 0;
  int          n_cs = 0;

  always @(negedge clk) begin
    if (bus.w_wr_en === 1'b1) begin
      if (wq.size() == 0) begin
        chk("w_spurious", 1, 0);
      end else begin
        logic [33:0] e;
        int          ix;
        e  = wq.pop_front();
        ix = wi.pop_front();
        chk("w_wr", {bus.w_wr_layer, bus.w_wr_bias, bus.w_wr_addr, bus.w_wr_data}, e);
        if (ix == L1_B_BASE)
          chk("w_l1_bias0", {bus.w_wr_layer, bus.w_wr_bias, bus.w_wr_addr}, {2'd0, 1'b1, 15'd0});
        if (ix == L4_B_BASE + NN4 - 1)
          chk("w_l4_bias9", {bus.w_wr_layer, bus.w_wr_bias, bus.w_wr_addr}, {2'd3, 1'b1, 15'd9});
      end
      n_wr++;
    end
    if (bus.px_wr_en === 1'b1) begin
      if (pq.size() == 0) chk("px_spurious", 1, 0);
      else chk("px_wr", {bus.px_wr_addr, bus.px_wr_data}, pq.pop_front());
      n_px++;
    end
    if (bus.compute_start === 1'b1) begin
      n_cs++;
      chk("cs_with_last_px", {bus.px_wr_en, bus.px_wr_addr}, {1'b1, 10'(NO_OF_INPUTS - 1)});
    end
  end

  task automatic feed_pixels(input int n);
    int acc = 0;
    int cyc = 0;
    while (acc < n && cyc < 4000) begin
      chk("rta_img", bus.FNN_ready_to_accept, 1);
      bus.ready_in    = ($urandom_range(0, 9) < 7);
      bus.input_image = 16'($urandom);
      if (bus.ready_in) begin
        pq.push_back({10'(acc), bus.input_image});
        acc++;
      end
      @(negedge clk);
      cyc++;
    end
    bus.ready_in = 1'b0;
    if (acc < n) chk("px_timeout", acc, n);
  endtask

  task automatic stream_words(input int n_words, input int cyc_max, input bit gaps, input int bad_idx);
    int  idx = 0;
    int  cyc = 0;
    int  pause_left = 0;
    bit  paused = 0;
    int  layer, bias, addr, part;
    logic [WEIGHT_WIDTH-1:0] d;
    while (idx < n_words && cyc < cyc_max) begin
      bit go;
      if (gaps && !paused && idx == 15000) begin
        paused = 1;
        pause_left = 20;
      end
      if (pause_left > 0) begin
        bus.load_weights = 1'b0;
        bus.weight_valid = 1'($urandom_range(0, 1));
        pause_left--;
        go = 0;
      end else begin
        bus.load_weights = 1'b1;
        if (gaps && (idx < 3000 || (idx >= 14000 && idx < 17000)))
          bus.weight_valid = 1'($urandom_range(0, 1));
        else
          bus.weight_valid = 1'b1;
        go = bus.weight_valid;
      end
      bus.weight_bus = WBUS_W'($urandom);
      if (go) begin
        decode(idx, layer, bias, addr, part);
        if (idx == bad_idx) part = 3;
        d = WEIGHT_WIDTH'($urandom);
        bus.weight_bus = {7'(part), d};
        wq.push_back({2'(layer), 1'(bias), 15'(addr), d});
        wi.push_back(idx);
        if (idx == bad_idx) chk("err_before_bad", bus.err_part, 0);
        idx++;
        if (idx == DEPTH) chk("rdy_before_last", bus.FNN_ready, 0);
      end
      @(negedge clk);
      cyc++;
      if (go && idx == DEPTH) chk("rdy_after_last", bus.FNN_ready, 1);
      if (go && idx == bad_idx + 1) chk("err_after_bad", bus.err_part, 1);
    end
    bus.weight_valid = 1'b0;
    if (idx < n_words) chk("load_timeout", idx, n_words);
  endtask

  initial begin
    #700000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    restart          = 1'b0;
    bus.load_weights = 1'b0;
    bus.weight_valid = 1'b0;
    bus.weight_bus   = '0;
    bus.start_FNN    = 1'b0;
    bus.ready_in     = 1'b0;
    bus.input_image  = '0;
    bus.compute_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs", outs, 0);
    restart = 1'b1;
    @(negedge clk);

    // Word offered while still IDLE must be ignored.
    bus.load_weights = 1'b1;
    bus.weight_valid = 1'b1;
    bus.weight_bus   = WBUS_W'($urandom);
    @(negedge clk);
    stream_words(DEPTH, 60000, 1'b1, -1);

    // Extra words after the load completes are ignored.
    bus.load_weights = 1'b1;
    bus.weight_valid = 1'b1;
    repeat (5) @(negedge clk);
    bus.weight_valid = 1'b0;
    bus.load_weights = 1'b0;
    repeat (2) @(negedge clk);
    chk("w_count", n_wr, DEPTH);
    chk("wq_drained", wq.size(), 0);
    chk("err_clean", bus.err_part, 0);
    chk("rdy_level", bus.FNN_ready, 1);

    // compute_done outside WAIT has no effect.
    bus.compute_done = 1'b1;
    @(negedge clk);
    bus.compute_done = 1'b0;
    chk("rta_ready", bus.FNN_ready_to_accept, 0);

    bus.start_FNN = 1'b1;
    @(negedge clk);
    bus.start_FNN = 1'b0;
    feed_pixels(NO_OF_INPUTS);
    chk("rta_after_last", bus.FNN_ready_to_accept, 0);
    repeat (3) @(negedge clk);
    chk("cs_count", n_cs, 1);
    chk("px_count", n_px, NO_OF_INPUTS);
    chk("pq_drained", pq.size(), 0);

    bus.start_FNN = 1'b1;
    @(negedge clk);
    chk("rta_wait_start", bus.FNN_ready_to_accept, 0);
    bus.compute_done = 1'b1;
    @(negedge clk);
    bus.compute_done = 1'b0;
    chk("rta_back_ready", bus.FNN_ready_to_accept, 0);
    @(negedge clk);
    bus.start_FNN = 1'b0;
    chk("rta_reenter_img", bus.FNN_ready_to_accept, 1);

    // Second image aborted by reset at pixel 400.
    feed_pixels(400);
    bus.ready_in    = 1'b1;
    bus.input_image = 16'($urandom);
    restart         = 1'b0;
    @(negedge clk);
    chk("abort_outs", outs, 0);
    bus.ready_in = 1'b0;
    restart      = 1'b1;
    chk("abort_cs", n_cs, 1);
    chk("abort_px_count", n_px, NO_OF_INPUTS + 400);

    bus.start_FNN = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rta_after_abort", bus.FNN_ready_to_accept, 0);
    end
    bus.start_FNN = 1'b0;
    chk("rdy_after_abort", bus.FNN_ready, 0);

    // Partial reload with a mistagged word 5.
    n_wr = 0;
    bus.load_weights = 1'b1;
    @(negedge clk);
    stream_words(1000, 3000, 1'b0, 5);
    bus.load_weights = 1'b0;
    repeat (3) @(negedge clk);
    chk("reload_count", n_wr, 1000);
    chk("err_sticky", bus.err_part, 1);
    chk("rdy_partial", bus.FNN_ready, 0);
    chk("wq_drained2", wq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
